// File: rtl/boot_rom_arbiter.sv
// boot_rom_arbiter
//   Shares a single-port, 1-cycle-latency boot ROM between the instruction
//   fetch port (port 0) and the data-load port (port 1). At most one request
//   is granted per cycle. The response comes back one cycle later, tagged to
//   the port that owns it. A sticky lockout unmaps the ROM once boot
//   software is finished.
//
//   Optional build macro:
//     ROMARB_FIXED_PRI_EN - port 1 always wins contention (fixed priority).
//                           When the macro is undefined the arbiter is
//                           round-robin.
module boot_rom_arbiter #(
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = 10
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    p0_req,
  input  logic [ADDRESS_BITS-1:0] p0_addr,
  output logic                    p0_gnt,
  output logic                    p0_rvalid,
  input  logic                    p1_req,
  input  logic [ADDRESS_BITS-1:0] p1_addr,
  output logic                    p1_gnt,
  output logic                    p1_rvalid,
  output logic [BITS-1:0]         rdata,
  output logic                    rerr,
  input  logic                    lock,
  output logic                    locked,
  output logic [ADDRESS_BITS-1:0] rom_addr,
  input  logic [BITS-1:0]         rom_data
);

  // The port that most recently won. A value of 1 lets port 0 win the
  // first contention after reset.
  logic                    last_grant_q, last_grant_d;
  // The ROM address that was last driven. It is held between grants so the
  // ROM address bus does not toggle when nothing is granted.
  logic [ADDRESS_BITS-1:0] rom_addr_q;
  // One-hot owner of the response that is due in the next cycle.
  // The value 0 means no response is pending.
  logic [1:0]              owner_q, owner_d;
  // Set when the pending response was granted while the ROM was locked.
  logic                    err_q, err_d;
  logic                    locked_q, locked_d;
  logic [1:0]              req_w;
  logic [1:0]              gnt_w;

  assign req_w = {p1_req, p0_req};

  // Combinational grant from the requests and the previous winner.
  // Grants are suppressed while reset is asserted, so every output holds
  // its reset value during reset.
  always_comb begin
    gnt_w = 2'b00;
    if (RSTb) begin
      unique case (req_w)
        2'b01:   gnt_w = 2'b01;
        2'b10:   gnt_w = 2'b10;
`ifdef ROMARB_FIXED_PRI_EN
        2'b11:   gnt_w = 2'b10;
`else
        2'b11:   gnt_w = last_grant_q ? 2'b01 : 2'b10;
`endif
        default: gnt_w = 2'b00;
      endcase
    end
  end

  // ROM address steering and next-state logic for the response tracking
  // and the lockout.
  always_comb begin
    rom_addr     = rom_addr_q;
    last_grant_d = last_grant_q;
    owner_d      = gnt_w;
    err_d        = locked_q & (|gnt_w);
    locked_d     = locked_q | lock;
    if (gnt_w[0]) begin
      rom_addr     = locked_q ? '0 : p0_addr;
      last_grant_d = 1'b0;
    end else if (gnt_w[1]) begin
      rom_addr     = locked_q ? '0 : p1_addr;
      last_grant_d = 1'b1;
    end
  end

  // State registers. Reset also drops any response that is in flight.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      last_grant_q <= 1'b1;
      rom_addr_q   <= '0;
      owner_q      <= 2'b00;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
      if (|gnt_w) begin
        rom_addr_q <= rom_addr;
      end
    end
  end

  assign p0_gnt    = gnt_w[0];
  assign p1_gnt    = gnt_w[1];
  assign p0_rvalid = owner_q[0];
  assign p1_rvalid = owner_q[1];
  assign rerr      = (|owner_q) & err_q;
  // ROM data passes straight through only for a response that is valid and
  // was not blocked by the lockout. In every other case rdata is 0.
  assign rdata     = ((|owner_q) && !err_q) ? rom_data : '0;
  assign locked    = locked_q;

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Testbench for boot_rom_arbiter. It uses directed scenarios and randomized
// traffic, checked against a transaction-level reference model.
module tb_boot_rom_arbiter;
  localparam int BITS = 32;
  localparam int AW   = 10;
`ifdef ROMARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            p0_req, p1_req, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [AW-1:0]   p0_addr, p1_addr, rom_addr;
  logic [BITS-1:0] rdata, rom_data;
  logic            rerr, lock, locked;

  always #5 clk = ~clk;

  boot_rom_arbiter #(.BITS(BITS), .ADDRESS_BITS(AW)) dut (
    .CLK(clk), .RSTb(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .rerr(rerr), .lock(lock), .locked(locked),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  // Boot ROM: synchronous read with a latency of 1 cycle.
  logic [BITS-1:0] mem [1024];
  always @(posedge clk) rom_data <= mem[rom_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state. It works at the transaction level: the previous
  // winner, the last address driven, the lock flag, and a single pending
  // response.
  int              prev_winner;
  logic [AW-1:0]   last_addr_m;
  bit              locked_m;
  bit              pend_v;
  int              pend_port;
  logic [BITS-1:0] pend_data;
  bit              pend_err;
  int              win;
  logic [AW-1:0]   win_addr;

  // Values the model expects for the cycle that is currently being driven.
  bit              exp_g0, exp_g1, exp_rv0, exp_rv1, exp_rerr, exp_locked;
  logic [AW-1:0]   exp_addr;
  logic [BITS-1:0] exp_rdata;

  task automatic model_reset();
    prev_winner = 1; last_addr_m = '0; locked_m = 1'b0; pend_v = 1'b0;
    pend_port = 0; pend_data = '0; pend_err = 1'b0; win = -1; win_addr = '0;
  endtask

  // Apply the inputs for one cycle and work out what the model expects.
  task automatic drive(input bit r0, input logic [AW-1:0] a0,
                       input bit r1, input logic [AW-1:0] a1, input bit lk);
    p0_req = r0; p0_addr = a0; p1_req = r1; p1_addr = a1; lock = lk;
    if (r0 && r1) win = FIXED ? 1 : ((prev_winner == 0) ? 1 : 0);
    else if (r0)  win = 0;
    else if (r1)  win = 1;
    else          win = -1;
    win_addr = (win == 1) ? a1 : a0;
    exp_g0 = (win == 0);
    exp_g1 = (win == 1);
    exp_addr   = (win < 0) ? last_addr_m : (locked_m ? '0 : win_addr);
    exp_rv0    = pend_v && (pend_port == 0);
    exp_rv1    = pend_v && (pend_port == 1);
    exp_rdata  = (pend_v && !pend_err) ? pend_data : '0;
    exp_rerr   = pend_v && pend_err;
    exp_locked = locked_m;
  endtask

  // Advance one clock edge and commit the model's view of that cycle.
  task automatic tick();
    @(posedge clk);
    if (win >= 0) begin
      pend_v = 1'b1; pend_port = win; pend_data = mem[win_addr];
      pend_err = locked_m; prev_winner = win; last_addr_m = exp_addr;
    end else begin
      pend_v = 1'b0;
    end
    if (lock) locked_m = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rerr, locked} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rerr, locked}); end
    n_checks++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    $display("reset released");
  endtask

  task automatic test_single();
    drive(1'b1, 10'h005, 1'b0, '0, 1'b0);
    @(negedge clk);
    n_checks++; if (p0_gnt !== exp_g0 || p1_gnt !== exp_g1) begin
      n_fail++; $display("FAIL single_gnt: got %b%b expected %b%b", p0_gnt, p1_gnt, exp_g0, exp_g1); end
    n_checks++; if (rom_addr !== exp_addr) begin n_fail++; $display("FAIL single_rom_addr: got %h expected %h", rom_addr, exp_addr); end
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    n_checks++; if (p0_rvalid !== exp_rv0 || p1_rvalid !== exp_rv1) begin
      n_fail++; $display("FAIL single_rvalid: got %b%b expected %b%b", p0_rvalid, p1_rvalid, exp_rv0, exp_rv1); end
    n_checks++; if (rdata !== exp_rdata || rerr !== exp_rerr) begin
      n_fail++; $display("FAIL single_rdata: got %h/%b expected %h/%b", rdata, rerr, exp_rdata, exp_rerr); end
    $display("single: p0 resp rdata=%h rerr=%b", rdata, rerr);
    tick();
  endtask

  task automatic test_contention();
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(1'b1, 10'h010, 1'b1, 10'h020, 1'b0);
      else       drive(1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      n_checks++; if (p0_gnt !== exp_g0 || p1_gnt !== exp_g1 || (p0_gnt && p1_gnt)) begin
        n_fail++; $display("FAIL cont_gnt[%0d]: got %b%b expected %b%b", i, p0_gnt, p1_gnt, exp_g0, exp_g1); end
      n_checks++; if (rom_addr !== exp_addr) begin n_fail++; $display("FAIL cont_rom_addr[%0d]: got %h expected %h", i, rom_addr, exp_addr); end
      if (i > 0) begin
        n_checks++; if (p0_rvalid !== exp_rv0 || p1_rvalid !== exp_rv1 || rdata !== exp_rdata) begin
          n_fail++; $display("FAIL cont_resp[%0d]: got %b%b/%h expected %b%b/%h", i, p0_rvalid, p1_rvalid, rdata, exp_rv0, exp_rv1, exp_rdata); end
        $display("contention cycle %0d: gnt=%b%b resp=%b%b rdata=%h", i, p1_gnt, p0_gnt, p1_rvalid, p0_rvalid, rdata);
      end
      tick();
    end
  endtask

  task automatic test_streaming();
    logic [AW-1:0] addrs [3];
    addrs[0] = 10'h3FF; addrs[1] = 10'h000; addrs[2] = 10'h001;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b0, '0, 1'b1, addrs[i], 1'b0);
      else       drive(1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      n_checks++; if (p1_gnt !== exp_g1 || rom_addr !== exp_addr) begin
        n_fail++; $display("FAIL stream_gnt[%0d]: got %b/%h expected %b/%h", i, p1_gnt, rom_addr, exp_g1, exp_addr); end
      if (i > 0) begin
        n_checks++; if (p1_rvalid !== 1'b1 || rdata !== mem[addrs[i-1]] || rdata !== exp_rdata) begin
          n_fail++; $display("FAIL stream_resp[%0d]: got %b/%h expected 1/%h", i, p1_rvalid, rdata, mem[addrs[i-1]]); end
        $display("stream resp p1 addr=%h rdata=%h", addrs[i-1], rdata);
      end
      tick();
    end
  endtask

  task automatic test_random(input int ncyc, input bit use_lock);
    bit r0 = 1'b0, r1 = 1'b0, lk;
    logic [AW-1:0] a0 = '0, a1 = '0;
    for (int i = 0; i < ncyc; i++) begin
      // An address may change only when the port has no request outstanding,
      // that is, when its req was low or it was just granted.
      if (!r0 || exp_g0) a0 = AW'($urandom_range(0, 1023));
      if (!r1 || exp_g1) a1 = AW'($urandom_range(0, 1023));
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      lk = use_lock && ($urandom_range(0, 15) == 0);
      drive(r0, a0, r1, a1, lk);
      @(negedge clk);
      n_checks++; if (p0_gnt !== exp_g0 || p1_gnt !== exp_g1) begin
        n_fail++; $display("FAIL rand_gnt[%0d]: got %b%b expected %b%b", i, p0_gnt, p1_gnt, exp_g0, exp_g1); end
      n_checks++; if (rom_addr !== exp_addr) begin n_fail++; $display("FAIL rand_rom_addr[%0d]: got %h expected %h", i, rom_addr, exp_addr); end
      n_checks++; if (p0_rvalid !== exp_rv0 || p1_rvalid !== exp_rv1) begin
        n_fail++; $display("FAIL rand_rvalid[%0d]: got %b%b expected %b%b", i, p0_rvalid, p1_rvalid, exp_rv0, exp_rv1); end
      n_checks++; if (rdata !== exp_rdata || rerr !== exp_rerr) begin
        n_fail++; $display("FAIL rand_rdata[%0d]: got %h/%b expected %h/%b", i, rdata, rerr, exp_rdata, exp_rerr); end
      n_checks++; if (locked !== exp_locked) begin n_fail++; $display("FAIL rand_locked[%0d]: got %b expected %b", i, locked, exp_locked); end
      if (exp_rv0 || exp_rv1) $display("rand resp p%0d rdata=%h rerr=%b", exp_rv1 ? 1 : 0, rdata, rerr);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic test_lockout();
    drive(1'b1, 10'h004, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_checks++; if (p0_gnt !== 1'b1 || rom_addr !== 10'h004 || locked !== 1'b0) begin
      n_fail++; $display("FAIL lock_grant: got %b/%h/%b expected 1/004/0", p0_gnt, rom_addr, locked); end
    tick();
    drive(1'b0, '0, 1'b1, 10'h004, 1'b0);
    @(negedge clk);
    n_checks++; if (p0_rvalid !== 1'b1 || rdata !== mem[4] || rerr !== 1'b0) begin
      n_fail++; $display("FAIL lock_pre_resp: got %b/%h/%b expected 1/%h/0", p0_rvalid, rdata, rerr, mem[4]); end
    n_checks++; if (locked !== 1'b1 || p1_gnt !== 1'b1 || rom_addr !== '0) begin
      n_fail++; $display("FAIL lock_state: got %b/%b/%h expected 1/1/000", locked, p1_gnt, rom_addr); end
    $display("lock: p0 resp rdata=%h rerr=%b", rdata, rerr);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    n_checks++; if (p1_rvalid !== 1'b1 || rdata !== '0 || rerr !== 1'b1) begin
      n_fail++; $display("FAIL lock_post_resp: got %b/%h/%b expected 1/0/1", p1_rvalid, rdata, rerr); end
    $display("lock: p1 resp rdata=%h rerr=%b", rdata, rerr);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, '0, 1'b1, 10'h123, 1'b0);
    @(negedge clk);
    n_checks++; if (p1_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt: got %b expected 1", p1_gnt); end
    #2 rst_n = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1; lock = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rerr, locked} !== 6'b0 || rdata !== '0 || rom_addr !== '0) begin
        n_fail++; $display("FAIL rstmid_outputs[%0d]: got %b/%h/%h expected 000000/0/0", i,
          {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rerr, locked}, rdata, rom_addr); end
    end
    @(posedge clk); #1;
    model_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (p1_rvalid !== 1'b0 || p0_rvalid !== 1'b0 || locked !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_dropped: got %b%b/%b expected 00/0", p1_rvalid, p0_rvalid, locked); end
    tick();
    drive(1'b1, 10'h0AA, 1'b1, 10'h055, 1'b0);
    @(negedge clk);
    n_checks++; if (p0_gnt !== exp_g0 || p1_gnt !== exp_g1) begin
      n_fail++; $display("FAIL rstmid_first_win: got %b%b expected %b%b", p0_gnt, p1_gnt, exp_g0, exp_g1); end
    $display("after reset: first contention gnt=%b%b", p1_gnt, p0_gnt);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
  endtask

`ifdef ROMARB_FIXED_PRI_EN
  task automatic test_fixed_pri();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, 10'h011, 1'b1, 10'h022, 1'b0);
      else       drive(1'b1, 10'h011, 1'b0, '0, 1'b0);
      @(negedge clk);
      n_checks++; if (p0_gnt !== (i == 4) || p1_gnt !== (i < 4) || p0_gnt !== exp_g0) begin
        n_fail++; $display("FAIL fixed_pri[%0d]: got %b%b expected %b%b", i, p0_gnt, p1_gnt, i == 4, i < 4); end
      $display("fixed pri cycle %0d: gnt=%b%b", i, p1_gnt, p0_gnt);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_streaming();
    test_random(300, 1'b0);
    test_lockout();
    test_random(100, 1'b1);
    test_reset_mid();
`ifdef ROMARB_FIXED_PRI_EN
    test_fixed_pri();
`endif
    test_random(100, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/boot_rom_arbiter.md
Name: boot_rom_arbiter

Overview:
Two-port arbiter that shares the single-port, 1-cycle-latency boot ROM between the CPU instruction-fetch port (port 0) and the data-load port (port 1).
- Grants at most one request per cycle, drives the ROM address, and returns read data one cycle after grant, tagged to the owning port.
- Provides a sticky lockout that unmaps the ROM once boot software is done.
- Sits between the CPU bus front-end and the boot ROM.

Parameters:
BITS, 32, ROM data width.
ADDRESS_BITS, 10, ROM word-address width.

Ports:
CLK  input  1  system clock, all state on rising edge.
RSTb  input  1  asynchronous active-low reset.
p0_req  input  1  fetch port request; p0_addr must be stable while asserted.
p0_addr  input  ADDRESS_BITS  fetch port word address.
p0_gnt  output  1  fetch request accepted this cycle.
p0_rvalid  output  1  fetch read data valid on rdata.
p1_req  input  1  data port request.
p1_addr  input  ADDRESS_BITS  data port word address.
p1_gnt  output  1  data request accepted this cycle.
p1_rvalid  output  1  data read data valid on rdata.
rdata  output  BITS  shared read-data bus.
rerr  output  1  qualifies rvalid: access made while locked.
lock  input  1  set sticky ROM lockout.
locked  output  1  current lockout state.
rom_addr  output  ADDRESS_BITS  address to ROM.
rom_data  input  BITS  ROM output, valid the cycle after rom_addr is sampled.

Behaviour:
- Reset values: p0_gnt=0, p1_gnt=0, p0_rvalid=0, p1_rvalid=0, rerr=0, locked=0, rdata=0, rom_addr=0, last_grant=1. With last_grant=1, port 0 wins the first contention.
- Grant logic is combinational from req and last_grant.
  - Only one req high: grant that port.
  - Both high: grant the port that is not last_grant (round-robin).
  - last_grant updates on every grant.
- rom_addr is the granted port's address in the grant cycle. With no grant it holds its previous value, so there is no spurious toggling.
- Response timing:
  - Grant in cycle N gives the owner's rvalid high in cycle N+1, for exactly one cycle.
  - rdata = rom_data in that cycle, passed through combinationally from rom_data.
  - Owner tag is a 2-bit registered response-pending/owner flop set in cycle N.
  - rdata is 0 when no rvalid is high.
- Throughput and handshake:
  - Back-to-back grants are allowed; one grant per cycle sustains full throughput.
  - A port holding req high after a grant may present a new address and be regranted next cycle, subject to round-robin.
  - Under continuous contention, grants alternate 0,1,0,1.
  - A requester may deassert req only in the cycle after gnt; deasserting without a grant is permitted (withdrawal), and no response is generated.
- Simultaneous response and new grant are normal and do not conflict: a response goes to one port while the next grant goes to either port.
- Lockout:
  - locked sets on the first rising edge with lock=1. It is sticky and cleared only by RSTb.
  - While locked, requests are still arbitrated and granted identically, but rom_addr is forced to 0.
  - The response has rdata=0 and rerr=1 with rvalid.
  - A grant issued before the lock edge completes normally (rerr=0, real data).
- Reset mid-operation: asserting RSTb clears any pending response immediately. That response is dropped and no rvalid is ever produced for it.

Optional Feature:
ROMARB_FIXED_PRI_EN
- Defined: fixed priority, port 1 (data) always wins contention. last_grant still updates but is ignored, and port 0 is starved while p1_req is held.
- Undefined: round-robin as specified above.

Test Plan:
1. Reset, p0_req=1 p0_addr=0x005 one cycle -> p0_gnt same cycle, rom_addr=0x005; next cycle p0_rvalid=1, rdata=MEM[5], rerr=0, p1_rvalid=0.
2. p0_req and p1_req held high 6 cycles, addresses 0x010/0x020 -> grants 0,1,0,1,0,1; each rvalid one cycle later with matching MEM data; never both gnt high.
3. p1_req only, addresses 0x3FF,0x000,0x001 on consecutive cycles -> three consecutive grants and three consecutive p1_rvalid pulses with MEM[0x3FF], MEM[0], MEM[1].
4. Grant p0 at 0x004 in cycle N with lock pulsed in cycle N, then p1 request at 0x004 -> p0 response real data, rerr=0; p1 response rdata=0, rerr=1; locked stays 1 until RSTb.
5. Grant p1 then assert RSTb before the response cycle -> no p1_rvalid; all outputs at reset values while RSTb=0; after release, port 0 wins the first contention.
6. With ROMARB_FIXED_PRI_EN, both req held 4 cycles -> p1_gnt all 4 cycles, p0_gnt=0; drop p1_req -> p0 granted next cycle.
